// File: rtl/rst_seq.sv
// rst_seq: staged reset release sequencer with soft re-sequence request.
// Define RST_SEQ_WDT_EN to add a watchdog that re-sequences when KICK stops.
module rst_seq #(
   parameter int STAGES    = 4,
   parameter int HOLD_CYC  = 16,
   parameter int STAGE_DLY = 256,
   parameter int CNT_W     = 16,
   parameter int WDT_CYC   = 1048576
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_req,
   input  logic              kick,
   output logic [STAGES-1:0] rst_out,
   output logic              ready,
   output logic              wdt_fired
);
   typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;
   state_t state;
   logic [CNT_W-1:0] cnt, lim;
   logic [STAGES-1:0] nxt;
   logic restart;
   assign lim = state == ASSERT ? CNT_W'(HOLD_CYC - 1) : CNT_W'(STAGE_DLY - 1);
   // thermometer release: shifting in a zero clears the next stage
   assign nxt = rst_out << 1;
   always_ff @(posedge clk)
      if (rst || restart) begin
         state   <= ASSERT;
         cnt     <= '0;
         rst_out <= '1;
         ready   <= 1'b0;
      end else if (state != RUN) begin
         if (cnt == lim) begin
            cnt     <= '0;
            rst_out <= nxt;
            ready   <= ~|nxt;
            state   <= ~|nxt ? RUN : RELEASE;
         end else
            cnt <= cnt + 1'b1;
      end
`ifdef RST_SEQ_WDT_EN
   localparam int WDT_W = $clog2(WDT_CYC);
   logic [WDT_W-1:0] wdt;
   logic wdt_to;
   assign wdt_to  = state == RUN && wdt == WDT_W'(WDT_CYC - 1) && !kick;
   assign restart = soft_req || wdt_to;
   always_ff @(posedge clk)
      if (rst) begin
         wdt       <= '0;
         wdt_fired <= 1'b0;
      end else begin
         wdt       <= (state != RUN || kick || wdt_to) ? '0 : wdt + 1'b1;
         wdt_fired <= wdt_fired || wdt_to;
      end
`else
   logic unused_kick;
   assign unused_kick = kick;
   assign restart     = soft_req;
   assign wdt_fired   = 1'b0;
`endif
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: table-driven release timing checks with a scoreboard queue.
module tb_rst_seq;
   logic clk = 0, rst = 1, soft_req = 0, kick = 0, rst1 = 1;
   logic [3:0] rst_out;
   logic ready, wdt_fired;
   logic [0:0] rst_out1;
   logic ready1, wdt_fired1;
   always #5 clk = ~clk;
   rst_seq #(.WDT_CYC(100)) dut (
      .clk(clk), .rst(rst), .soft_req(soft_req), .kick(kick),
      .rst_out(rst_out), .ready(ready), .wdt_fired(wdt_fired));
   rst_seq #(.STAGES(1), .HOLD_CYC(1), .WDT_CYC(100)) dut1 (
      .clk(clk), .rst(rst1), .soft_req(1'b0), .kick(1'b0),
      .rst_out(rst_out1), .ready(ready1), .wdt_fired(wdt_fired1));
   typedef struct { int e; logic [3:0] ro; logic rdy; } vec_t;
   typedef struct { string nm; logic [3:0] ro; logic rdy; logic wf; } exp_t;
   vec_t tbl[8];
   exp_t sb[$];
   int nvec = 0, nerr = 0;
   logic wf_exp = 0;
   task automatic push(string nm, logic [3:0] ro, logic rdy, logic wf);
      sb.push_back('{nm, ro, rdy, wf});
   endtask
   task automatic pop_cmp(logic [3:0] ro, logic rdy, logic wf);
      exp_t x;
      nvec++;
      if (sb.size() == 0) begin
         nerr++;
         $display("FAIL scoreboard_empty: got rst_out=%h ready=%b wdt_fired=%b, nothing expected", ro, rdy, wf);
         return;
      end
      x = sb.pop_front();
      if ({ro, rdy, wf} !== {x.ro, x.rdy, x.wf}) begin
         nerr++;
         $display("FAIL %s: got rst_out=%h ready=%b wdt_fired=%b, want rst_out=%h ready=%b wdt_fired=%b",
                  x.nm, ro, rdy, wf, x.ro, x.rdy, x.wf);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // n counts edges from the first edge that samples the restart condition low
   task automatic run_seq(string nm, int upto);
      for (int n = 0; n <= upto; n++) begin
         foreach (tbl[i]) if (tbl[i].e == n) push($sformatf("%s@%0d", nm, n), tbl[i].ro, tbl[i].rdy, wf_exp);
         tick();
         while (sb.size() > 0) pop_cmp(rst_out, ready, wdt_fired);
      end
   endtask
   task automatic expect_cycle(string nm, logic [3:0] ro, logic rdy);
      push(nm, ro, rdy, wf_exp);
      tick();
      pop_cmp(rst_out, ready, wdt_fired);
   endtask
   initial begin
      tbl = '{'{14, 4'hF, 1'b0}, '{15, 4'hE, 1'b0}, '{270, 4'hE, 1'b0}, '{271, 4'hC, 1'b0},
              '{526, 4'hC, 1'b0}, '{527, 4'h8, 1'b0}, '{782, 4'h8, 1'b0}, '{783, 4'h0, 1'b1}};
      repeat (3) tick();
      push("reset", 4'hF, 1'b0, 1'b0);
      pop_cmp(rst_out, ready, wdt_fired);
      push("reset_s1", 4'h1, 1'b0, 1'b0);
      pop_cmp({3'b0, rst_out1}, ready1, wdt_fired1);
      rst1 = 0;
      for (int i = 0; i < 3; i++) begin
         push($sformatf("s1_edge%0d", i), 4'h0, 1'b1, 1'b0);
         tick();
         pop_cmp({3'b0, rst_out1}, ready1, wdt_fired1);
      end
      rst = 0;
      run_seq("seq", 783);
      kick = 1;
      for (int i = 0; i < 2000; i++) expect_cycle("ready_hold", 4'h0, 1'b1);
      kick = 0;
      soft_req = 1;
      for (int i = 0; i < 5; i++) expect_cycle("soft_hold", 4'hF, 1'b0);
      soft_req = 0;
      run_seq("soft_rerun", 783);
      soft_req = 1;
      expect_cycle("soft_pulse", 4'hF, 1'b0);
      soft_req = 0;
      run_seq("abort_pre", 300);
      soft_req = 1;
      expect_cycle("abort_mid", 4'hF, 1'b0);
      soft_req = 0;
      run_seq("abort_rerun", 783);
      soft_req = 1;
      expect_cycle("rst_pre_pulse", 4'hF, 1'b0);
      soft_req = 0;
      run_seq("rst_pre", 300);
      rst = 1;
      soft_req = 1;
      wf_exp = 0;
      expect_cycle("rst_mid", 4'hF, 1'b0);
      rst = 0;
      soft_req = 0;
      run_seq("rst_rerun", 783);
`ifdef RST_SEQ_WDT_EN
      for (int i = 1; i < 100; i++) expect_cycle("wdt_wait", 4'h0, 1'b1);
      wf_exp = 1;
      expect_cycle("wdt_fire", 4'hF, 1'b0);
      run_seq("wdt_rerun", 783);
      for (int i = 1; i < 100; i++) expect_cycle("kick_race_wait", 4'h0, 1'b1);
      kick = 1;
      expect_cycle("kick_race", 4'h0, 1'b1);
      kick = 0;
      soft_req = 1;
      expect_cycle("soft_keeps_fired", 4'hF, 1'b0);
      soft_req = 0;
      rst = 1;
      wf_exp = 0;
      expect_cycle("wdt_rst_clear", 4'hF, 1'b0);
      rst = 0;
      run_seq("kick_seq", 783);
      for (int i = 0; i < 500; i++) begin
         kick = (i % 50) == 49;
         expect_cycle("kick_50", 4'h0, 1'b1);
      end
      kick = 0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
